clk_div_cfg_ctrl: RTL and testbench

//  Upstream configuration stage for the integer clock divider: drives its clock-enable and divide-ratio inputs.

---
 rtl/clk_div_cfg_ctrl_if.sv | 15 +
 rtl/clk_div_cfg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_cfg_ctrl_if.sv
// Request channel of the divider configuration controller.
//   master : requester, drives valid/ratio/enable and samples ready
//   slave  : controller, samples the request and drives ready
// A transfer completes on a rising reference clock edge with valid & ready.
interface clk_div_cfg_ctrl_if #(
  parameter int RATIO_W = 4
);
  logic               I_req_valid;
  logic [RATIO_W-1:0] I_req_ratio;
  logic               I_req_en;
  logic               O_req_ready;

  modport master (output I_req_valid, I_req_ratio, I_req_en, input O_req_ready);
  modport slave  (input I_req_valid, I_req_ratio, I_req_en, output O_req_ready);
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: configuration front end for an integer clock divider.
// Accepts ratio/enable change requests and applies them only on a rising
// edge of the divider's own output (fed back on I_div_clk), so the divider
// never sees a ratio swap mid-phase. If no edge arrives within TIMEOUT_CYC
// reference cycles the change is forced and O_timeout pulses. After every
// apply the block stays busy for SETTLE_CYC cycles before accepting again.
//
// Ports:
//   I_ref_clk, I_rst_n : reference clock, async active-low reset
//   req (slave)        : I_req_valid/I_req_ratio/I_req_en in, O_req_ready out
//   I_div_clk          : divider output feedback (ref-clk domain)
//   O_clk_en           : divider clock enable
//   O_div_ratio        : divider ratio
//   O_busy             : change pending or settling
//   O_timeout          : 1-cycle pulse, change forced without an edge
//   O_err              : 1-cycle pulse, illegal request seen
//
// Build option: CLK_DIV_CFG_CLAMP_EN
//   defined   : illegal ratios are clamped into 1..MAX_RATIO and applied
//   undefined : illegal requests are handshaked but dropped
//   O_err pulses in both builds.
module clk_div_cfg_ctrl #(
  parameter int RATIO_W     = 4,
  parameter int MAX_RATIO   = 15,
  parameter int RESET_RATIO = 1,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic               I_ref_clk,
  input  logic               I_rst_n,
  clk_div_cfg_ctrl_if.slave  req,
  input  logic               I_div_clk,
  output logic               O_clk_en,
  output logic [RATIO_W-1:0] O_div_ratio,
  output logic               O_busy,
  output logic               O_timeout,
  output logic               O_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0]  ST_LAST = ST_W'(SETTLE_CYC - 1);
  // One extra bit so the upper-bound compare stays meaningful when
  // MAX_RATIO is the largest value the bus can carry.
  localparam logic [RATIO_W:0] MAX_X   = (RATIO_W + 1)'(MAX_RATIO);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_div_d;
  logic               r_clk_en;
  logic [RATIO_W-1:0] r_div_ratio;
  logic               r_lat_en;
  logic [RATIO_W-1:0] r_lat_ratio;
  logic [TO_W-1:0]    r_to_cnt;
  logic [ST_W-1:0]    r_st_cnt;
  logic               r_timeout, r_err;

  logic               w_ready, w_accept, w_rise, w_legal, w_take, w_fast;
  logic [RATIO_W:0]   w_ratio_x;
  logic [RATIO_W-1:0] w_ratio_fix;
  logic               w_apply, w_apply_en, w_latch, w_to_hit, w_err_nxt;
  logic [RATIO_W-1:0] w_apply_ratio;

  // Ready is held low while reset is asserted, high in IDLE otherwise.
  assign w_ready   = (r_state == S_IDLE) & I_rst_n;
  assign w_accept  = req.I_req_valid & w_ready;
  assign w_rise    = I_div_clk & ~r_div_d;
  assign w_ratio_x = {1'b0, req.I_req_ratio};
  // Ratio only matters when the divider is to be enabled.
  assign w_legal   = ~req.I_req_en | ((w_ratio_x != '0) && (w_ratio_x <= MAX_X));

`ifdef CLK_DIV_CFG_CLAMP_EN
  assign w_ratio_fix = w_legal ? req.I_req_ratio :
                       (req.I_req_ratio == '0) ? RATIO_W'(1) : RATIO_W'(MAX_RATIO);
  assign w_take      = 1'b1;
`else
  assign w_ratio_fix = req.I_req_ratio;
  assign w_take      = w_legal;
`endif

  // No edge to wait for when the divider is stopped or passing the
  // reference straight through; a no-op request also applies at once.
  assign w_fast = ~r_clk_en | (r_div_ratio <= RATIO_W'(1)) |
                  ((req.I_req_en == r_clk_en) && (w_ratio_fix == r_div_ratio));

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_apply       = 1'b0;
    w_apply_en    = r_lat_en;
    w_apply_ratio = r_lat_ratio;
    w_latch       = 1'b0;
    w_to_hit      = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_err_nxt = ~w_legal;
          if (w_take) begin
            if (w_fast) begin
              w_apply       = 1'b1;
              w_apply_en    = req.I_req_en;
              w_apply_ratio = w_ratio_fix;
              w_state_nxt   = S_SETTLE;
            end else begin
              w_latch     = 1'b1;
              w_state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        // A real edge wins over a coincident timeout.
        if (w_rise) begin
          w_apply     = 1'b1;
          w_state_nxt = S_SETTLE;
        end else if (r_to_cnt == TO_MAX) begin
          w_apply     = 1'b1;
          w_to_hit    = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_st_cnt == ST_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_div_d     <= 1'b0;
      r_clk_en    <= 1'b0;
      r_div_ratio <= RATIO_W'(RESET_RATIO);
      r_lat_en    <= 1'b0;
      r_lat_ratio <= '0;
      r_to_cnt    <= '0;
      r_st_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_div_d   <= I_div_clk;
      r_timeout <= w_to_hit;
      r_err     <= w_err_nxt;
      if (w_apply) begin
        r_clk_en    <= w_apply_en;
        r_div_ratio <= w_apply_ratio;
      end
      if (w_latch) begin
        r_lat_en    <= req.I_req_en;
        r_lat_ratio <= w_ratio_fix;
      end
      // Timeout counter saturates rather than wrapping.
      if (w_latch)                                     r_to_cnt <= '0;
      else if (r_state == S_WAIT && r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state != S_SETTLE)     r_st_cnt <= '0;
      else if (r_st_cnt != ST_LAST) r_st_cnt <= r_st_cnt + 1'b1;
    end
  end

  assign req.O_req_ready = w_ready;
  assign O_clk_en        = r_clk_en;
  assign O_div_ratio     = r_div_ratio;
  assign O_busy          = (r_state != S_IDLE);
  assign O_timeout       = r_timeout;
  assign O_err           = r_err;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl. The driver computes the expected
// outcome of each request from the behavioural rules and queues it; the
// monitor pops an entry whenever a request completes (ready returns after a
// busy period, or an illegal request is dropped) and compares.
module tb_clk_div_cfg_ctrl;

  localparam int MAXR = 15;

  logic       clk, rst_n, div_clk;
  logic       o_en, o_busy, o_to, o_err;
  logic [3:0] o_ratio;
  int         cyc = 0;
  int         tests = 0, fails = 0;

  clk_div_cfg_ctrl_if #(.RATIO_W(4)) req_if ();

  clk_div_cfg_ctrl #(.RATIO_W(4), .MAX_RATIO(MAXR), .RESET_RATIO(1),
                     .SETTLE_CYC(2), .TIMEOUT_CYC(32)) dut (
    .I_ref_clk(clk), .I_rst_n(rst_n), .req(req_if), .I_div_clk(div_clk),
    .O_clk_en(o_en), .O_div_ratio(o_ratio), .O_busy(o_busy),
    .O_timeout(o_to), .O_err(o_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int acc; int lat; bit en; int ratio; int nerr; int nto; bit chg;
  } exp_t;
  exp_t q[$];

  bit m_en;
  int m_ratio;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mode 0: pulse div_clk d cycles after accept; mode 1: hold it low
  task automatic send(input bit en, input int ratio, input int mode, input int d);
    exp_t e;
    int   r, w;
    bit   legal, fast, drop;
    w = 0;
    while (!req_if.O_req_ready && w < 200) begin @(negedge clk); w++; end
    if (!req_if.O_req_ready) begin chk("ready_wait", 0, 1); return; end
    legal = !en || (ratio >= 1 && ratio <= MAXR);
    r = ratio; drop = 0; fast = 0;
    if (!legal) begin
`ifdef CLK_DIV_CFG_CLAMP_EN
      r = (ratio == 0) ? 1 : MAXR;
`else
      drop = 1;
`endif
    end
    e.nerr = legal ? 0 : 1;
    e.nto  = 0;
    if (drop) begin
      e.lat = 0; e.en = m_en; e.ratio = m_ratio; e.chg = 0;
    end else begin
      fast = !m_en || m_ratio <= 1 || (en == m_en && r == m_ratio);
      if (fast)           e.lat = 2;
      else if (mode == 1) begin e.lat = 34; e.nto = 1; end
      else                e.lat = d + 2;
      e.chg = (en != m_en) || (r != m_ratio);
      e.en = en; e.ratio = r;
      m_en = en; m_ratio = r;
    end
    req_if.I_req_valid = 1'b1;
    req_if.I_req_en    = en;
    req_if.I_req_ratio = 4'(ratio);
    @(negedge clk);
    e.acc = cyc;
    q.push_back(e);
    req_if.I_req_valid = 1'b0;
    req_if.I_req_en    = 1'($urandom);
    req_if.I_req_ratio = 4'($urandom);
    if (!drop && !fast && mode == 0) begin
      repeat (d - 1) @(negedge clk);
      div_clk = 1'b1;
      @(negedge clk);
      div_clk = 1'b0;
    end
    w = 0;
    while (q.size() != 0 && w < 80) begin @(negedge clk); w++; end
    if (q.size() != 0) begin chk("sb_drain", q.size(), 0); q.delete(); end
  endtask

  // Monitor / scoreboard checker
  initial begin
    exp_t e;
    int   nerr, nto, nchg, chg_at;
    bit   prev_rdy, p_en, ev;
    logic [3:0] p_ratio;
    nerr = 0; nto = 0; nchg = 0; chg_at = 0; prev_rdy = 1; p_en = 0; p_ratio = 1;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        prev_rdy = 1; nerr = 0; nto = 0; nchg = 0;
        p_en = o_en; p_ratio = o_ratio;
      end else begin
        if (o_err) nerr++;
        if (o_to)  nto++;
        if (o_en != p_en || o_ratio != p_ratio) begin nchg++; chg_at = cyc; end
        ev = (!prev_rdy && req_if.O_req_ready) ||
             (o_err && !o_busy && prev_rdy && req_if.O_req_ready);
        if (ev) begin
          if (q.size() == 0) chk("sb_unexpected_event", 1, 0);
          else begin
            e = q.pop_front();
            chk("latency", cyc - e.acc, e.lat);
            chk("clk_en", int'(o_en), int'(e.en));
            chk("ratio", int'(o_ratio), e.ratio);
            chk("err_pulses", nerr, e.nerr);
            chk("timeout_pulses", nto, e.nto);
            chk("output_changes", nchg, e.chg ? 1 : 0);
            if (e.chg) chk("apply_cycle", chg_at, e.acc + e.lat - 2);
          end
          nerr = 0; nto = 0; nchg = 0;
        end
        prev_rdy = req_if.O_req_ready;
        p_en = o_en; p_ratio = o_ratio;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en; int ratio, mode, d;
    rst_n = 0; div_clk = 0;
    req_if.I_req_valid = 0; req_if.I_req_en = 0; req_if.I_req_ratio = '0;
    m_en = 0; m_ratio = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_clk_en", int'(o_en), 0);
    chk("rst_ratio", int'(o_ratio), 1);
    chk("rst_ready", int'(req_if.O_req_ready), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_timeout", int'(o_to), 0);
    chk("rst_err", int'(o_err), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("ready_after_rst", int'(req_if.O_req_ready), 1);
    @(negedge clk);

    send(1, 4, 0, 1);    // stopped -> fast apply
    send(1, 7, 0, 3);    // edge-aligned change
    send(1, 6, 0, 5);
    send(1, 3, 1, 0);    // no edge: forced apply
    send(1, 0, 0, 2);    // illegal ratio
    send(1, 9, 0, 2);
    send(1, 9, 0, 1);    // identical request
    send(0, 0, 0, 1);    // stop, ratio field latched anyway
    send(1, 5, 0, 4);

    for (int i = 0; i < 40; i++) begin
      en    = ($urandom % 5) != 0;
      ratio = $urandom % 16;
      if ($urandom % 8 == 0) ratio = 0;
      mode  = ($urandom % 6 == 0) ? 1 : 0;
      d     = 1 + $urandom % 12;
      send(en, ratio, mode, d);
    end

    // Reset while a change is waiting for an edge
    send(1, 5, 0, 2);
    send(1, 9, 0, 1);
    while (!req_if.O_req_ready) @(negedge clk);
    req_if.I_req_valid = 1; req_if.I_req_en = 1; req_if.I_req_ratio = 4'd12;
    @(negedge clk);
    req_if.I_req_valid = 0;
    repeat (6) @(negedge clk);
    chk("pending_busy", int'(o_busy), 1);
    chk("pending_ratio_held", int'(o_ratio), 9);
    rst_n = 0;
    #1;
    chk("midrst_clk_en", int'(o_en), 0);
    chk("midrst_ratio", int'(o_ratio), 1);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_ready", int'(req_if.O_req_ready), 0);
    @(negedge clk);
    rst_n = 1;
    m_en = 0; m_ratio = 1;
    div_clk = 1;
    repeat (40) @(negedge clk);
    div_clk = 0;
    chk("postrst_ratio", int'(o_ratio), 1);
    chk("postrst_clk_en", int'(o_en), 0);
    chk("postrst_busy", int'(o_busy), 0);
    chk("postrst_ready", int'(req_if.O_req_ready), 1);
    @(negedge clk);
    send(1, 2, 0, 1);

    chk("sb_empty_at_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
